// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous memory port: IDLE -> ACCESS -> WAIT -> DONE.
// Define MEM_ARB_FIXED_PRIO_EN to make ext win ties (no round-robin pointer).
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wd,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wd,
    output logic                  core_ack,
    output logic                  ext_ack,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  gnt_core,
    output logic                  gnt_ext,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t state;
    logic   acc_we;
    logic   sel_ext;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic   last_ext;
`endif

    always_comb begin
        sel_ext = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        sel_ext = ext_req;
`else
        // On a tie the requester that did not own the port last time wins.
        if (core_req && ext_req) sel_ext = ~last_ext;
        else                     sel_ext = ext_req;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            acc_we     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            gnt_core   <= 1'b0;
            gnt_ext    <= 1'b0;
            busy       <= 1'b0;
            core_ack   <= 1'b0;
            ext_ack    <= 1'b0;
            core_rdata <= '0;
            ext_rdata  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_ext   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (core_req || ext_req) begin
                        state    <= ACCESS;
                        gnt_core <= ~sel_ext;
                        gnt_ext  <= sel_ext;
                        busy     <= 1'b1;
                        acc_we   <= sel_ext ? ext_we   : core_we;
                        mem_we   <= sel_ext ? ext_we   : core_we;
                        mem_addr <= sel_ext ? ext_addr : core_addr;
                        mem_wd   <= sel_ext ? ext_wd   : core_wd;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_ext <= sel_ext;
`endif
                    end
                end
                ACCESS: begin
                    state  <= WAIT;
                    mem_we <= 1'b0;
                end
                WAIT: begin
                    // Memory output now reflects the address presented in ACCESS.
                    state    <= DONE;
                    core_ack <= gnt_core;
                    ext_ack  <= gnt_ext;
                    if (!acc_we) begin
                        if (gnt_ext) ext_rdata  <= mem_q;
                        else         core_rdata <= mem_q;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    core_ack <= 1'b0;
                    ext_ack  <= 1'b0;
                    gnt_core <= 1'b0;
                    gnt_ext  <= 1'b0;
                    busy     <= 1'b0;
                    acc_we   <= 1'b0;
                    mem_addr <= '0;
                    mem_wd   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// reset-abort, dropped-request and back-to-back sequences against a 16-word memory model.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, ext_req, ext_we;
    logic [AW-1:0] core_addr, ext_addr, mem_addr;
    logic [DW-1:0] core_wd, ext_wd, mem_wd, mem_q;
    logic [DW-1:0] core_rdata, ext_rdata;
    logic          core_ack, ext_ack, mem_we, gnt_core, gnt_ext, busy;
    logic          mem_load;
    logic [DW-1:0] mem [16];

    int errs = 0;
    int checks = 0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wd(core_wd),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
        .core_ack(core_ack), .ext_ack(ext_ack),
        .core_rdata(core_rdata), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_q(mem_q),
        .gnt_core(gnt_core), .gnt_ext(gnt_ext), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 5) ? 32'hDEAD_BEEF : 32'hA000_0000 + DW'(i);
    endfunction

    // Synchronous memory: one-cycle read latency, write on mem_we.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else begin
            if (mem_we) mem[mem_addr[3:0]] <= mem_wd;
            mem_q <= mem[mem_addr[3:0]];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drop_reqs();
        core_req = 1'b0;
        ext_req  = 1'b0;
    endtask

    typedef struct {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          ereq;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        logic          exp_ext;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam int NV = 11;
    vec_t v [NV];

    initial begin
        int  acks;
        logic oe;

        // creq cwe caddr cwd | ereq ewe eaddr ewd | winner, owner rdata after DONE
        v[0]  = '{1, 0, 5,  0,            0, 0, 0,  0,            0, 32'hDEAD_BEEF};
        v[1]  = '{0, 0, 0,  0,            1, 1, 3,  32'h1234_5678, 1, 32'h0000_0000};
        v[2]  = '{1, 0, 3,  0,            0, 0, 0,  0,            0, 32'h1234_5678};
        v[3]  = '{1, 0, 7,  0,            1, 0, 9,  0,            1, 32'hA000_0009};
        v[4]  = '{1, 0, 2,  0,            1, 0, 4,  0,            0, 32'hA000_0002};
        v[5]  = '{1, 0, 8,  0,            0, 0, 0,  0,            0, 32'hA000_0008};
        v[6]  = '{1, 1, 10, 32'hCAFE_F00D, 1, 0, 11, 0,            1, 32'hA000_000B};
        v[7]  = '{0, 0, 0,  0,            1, 1, 12, 32'h55AA_55AA, 1, 32'hA000_000B};
        v[8]  = '{0, 0, 0,  0,            1, 0, 12, 0,            1, 32'h55AA_55AA};
        v[9]  = '{1, 1, 1,  32'h0BAD_F00D, 1, 0, 0,  0,            0, 32'hA000_0008};
        v[10] = '{1, 0, 1,  0,            0, 0, 0,  0,            0, 32'h0BAD_F00D};

        reset = 1'b0;
        mem_load = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wd = 0;
        ext_req = 0;  ext_we = 0;  ext_addr = 0;  ext_wd = 0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst busy", busy, 1'b0);
        chkb("rst mem_we", mem_we, 1'b0);
        chkb("rst gnt_core", gnt_core, 1'b0);
        chkb("rst gnt_ext", gnt_ext, 1'b0);
        chkb("rst core_ack", core_ack, 1'b0);
        chk("rst mem_addr", mem_addr, '0);
        chk("rst core_rdata", core_rdata, '0);
        chk("rst ext_rdata", ext_rdata, '0);
        mem_load = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            core_req = v[i].creq; core_we = v[i].cwe; core_addr = v[i].caddr; core_wd = v[i].cwd;
            ext_req  = v[i].ereq; ext_we  = v[i].ewe; ext_addr  = v[i].eaddr; ext_wd  = v[i].ewd;
            oe = v[i].exp_ext;
            @(posedge clk); @(negedge clk);
            chkb($sformatf("v%0d access gnt_core", i), gnt_core, !oe);
            chkb($sformatf("v%0d access gnt_ext", i), gnt_ext, oe);
            chkb($sformatf("v%0d access busy", i), busy, 1'b1);
            chkb($sformatf("v%0d access mem_we", i), mem_we, oe ? v[i].ewe : v[i].cwe);
            chk($sformatf("v%0d access mem_addr", i), mem_addr, oe ? v[i].eaddr : v[i].caddr);
            chk($sformatf("v%0d access mem_wd", i), mem_wd, oe ? v[i].ewd : v[i].cwd);
            @(negedge clk);
            chkb($sformatf("v%0d wait mem_we", i), mem_we, 1'b0);
            chk($sformatf("v%0d wait mem_addr", i), mem_addr, oe ? v[i].eaddr : v[i].caddr);
            chkb($sformatf("v%0d wait ack", i), core_ack | ext_ack, 1'b0);
            @(negedge clk);
            chkb($sformatf("v%0d done core_ack", i), core_ack, !oe);
            chkb($sformatf("v%0d done ext_ack", i), ext_ack, oe);
            chkb($sformatf("v%0d done gnt", i), oe ? gnt_ext : gnt_core, 1'b1);
            chk($sformatf("v%0d done rdata", i), oe ? ext_rdata : core_rdata, v[i].exp_rdata);
            @(posedge clk); #1;
            drop_reqs();
            @(negedge clk);
            chkb($sformatf("v%0d idle busy", i), busy, 1'b0);
            chkb($sformatf("v%0d idle ack", i), core_ack | ext_ack, 1'b0);
            chkb($sformatf("v%0d idle gnt", i), gnt_core | gnt_ext, 1'b0);
            chk($sformatf("v%0d idle mem_addr", i), mem_addr, '0);
            chk($sformatf("v%0d idle mem_wd", i), mem_wd, '0);
        end

        // Reset asserted during WAIT of an ext-owned access (core owned last).
        @(posedge clk); #1;
        core_req = 1; core_we = 0; core_addr = 5;
        ext_req = 1;  ext_we = 0;  ext_addr = 9;
        @(posedge clk); @(negedge clk);
        chkb("rr tie to ext", gnt_ext, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chkb("mid rst busy", busy, 1'b0);
        chkb("mid rst mem_we", mem_we, 1'b0);
        chkb("mid rst gnt", gnt_core | gnt_ext, 1'b0);
        chkb("mid rst ack", core_ack | ext_ack, 1'b0);
        chk("mid rst mem_addr", mem_addr, '0);
        chk("mid rst mem_wd", mem_wd, '0);
        chk("mid rst core_rdata", core_rdata, '0);
        chk("mid rst ext_rdata", ext_rdata, '0);
        drop_reqs();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chkb($sformatf("post rst no ack %0d", k), core_ack | ext_ack, 1'b0);
            chkb($sformatf("post rst idle %0d", k), busy, 1'b0);
        end

        // First tie after reset goes to core; requests dropped mid-access still complete.
        @(posedge clk); #1;
        core_req = 1; core_we = 0; core_addr = 5;
        ext_req = 1;  ext_we = 0;  ext_addr = 9;
        @(posedge clk); @(negedge clk);
        chkb("post rst tie gnt_core", gnt_core, 1'b1);
        chkb("post rst tie gnt_ext", gnt_ext, 1'b0);
        drop_reqs();
        @(negedge clk);
        @(negedge clk);
        chkb("dropped req core_ack", core_ack, 1'b1);
        chkb("dropped req ext_ack", ext_ack, 1'b0);
        chk("dropped req rdata", core_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chkb("dropped req idle ack", core_ack, 1'b0);
        chkb("dropped req idle busy", busy, 1'b0);

        // Continuous core requests: ten accesses, one every four cycles.
        @(posedge clk); #1;
        core_req = 1; core_we = 0; core_addr = 5;
        acks = 0;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chkb($sformatf("b2b ack %0d", k), core_ack, (k % 4) == 2);
            chkb($sformatf("b2b busy %0d", k), busy, (k % 4) != 3);
            chkb($sformatf("b2b gnt %0d", k), gnt_core, (k % 4) != 3);
            if (core_ack) acks++;
            if (k == 38) core_req = 1'b0;
        end
        chk("b2b ack count", DW'(acks), 32'd10);
        repeat (2) @(negedge clk);
        chkb("b2b stays idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
